led_arbiter: RTL
================

# led_arbiter

Shares the FPGA-fabric 8-bit LED bank between several independent requesters: the HPS-driven `led_pio` export, a heartbeat generator, button echo and fault status. Sits in the top level between the `soc_system` PIO exports and the board LED pins. It grants one requester at a time using round-robin order with a minimum hold time, plus an optional strict-priority override for requester 0.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `LED_W`, 8, LED bus width
- `HOLD_CYCLES`, 50_000_000, minimum grant duration in clocks (≥1)
- `CNT_W`, 26, hold counter width; must satisfy 2^CNT_W ≥ HOLD_CYCLES

Ports:
- `clk_clk`  in  1  system clock; one clock domain only
- `reset_reset_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request level
- `req_led`  in  N_REQ*LED_W  requester i's pattern in bits [i*LED_W +: LED_W]
- `prio_lock`  in  1  when high, requester 0 preempts any owner
- `grant`  out  N_REQ  one-hot current owner; all-zero when idle
- `led_out`  out  LED_W  registered LED drive
- `busy`  out  1  high when any grant is active

## Operation
- States: IDLE and OWN.
- Reset values: IDLE; `grant`=0; `led_out`=0; `busy`=0; `hold_cnt`=0; `ptr`=N_REQ-1, so requester 0 wins the first search.
- **Round-robin search:** find the first set `req` bit, scanning from index `ptr`+1 upward with wrap at N_REQ.
- **IDLE:**
  - If any `req` is set, go to OWN with winner w.
  - `grant`←onehot(w), `ptr`←w, `hold_cnt`←0, `led_out`←`req_led[w]`.
- **OWN, hold counter:**
  - `hold_cnt` increments each cycle and saturates at HOLD_CYCLES-1.
  - `expired` = (`hold_cnt` == HOLD_CYCLES-1). With HOLD_CYCLES=1, `expired` is true in the first OWN cycle.
- **OWN, LED drive:** while `req[owner]` is high, `led_out`←`req_led[owner]` every cycle. If `req[owner]` drops before expiry, `led_out` freezes at its last value and the grant is held.
- **OWN, at or after expiry:**
  - If another requester is pending, hand over to the round-robin winner excluding the owner (new grant, `hold_cnt`←0, `ptr` updated).
  - Else if `req[owner]` is high, keep owning (counter stays saturated).
  - Else go to IDLE (`grant`=0, `led_out`=0).
- **Preemption:** if `prio_lock` and `req[0]` are both high and the owner is not 0, switch to requester 0 immediately, ignoring the hold. `ptr` is not updated on a preemption, so the rotation resumes afterwards.
- **Simultaneous events:** when preemption and expiry occur in the same cycle, preemption wins.
- `busy` = |`grant`.

## Timing
- Request to grant latency: `req` high in IDLE at cycle t gives `grant` and `led_out` valid at t+1.
- In OWN, `led_out` lags `req_led[owner]` by one cycle.
- Handover is glitch-free: `grant` changes one-hot to one-hot in a single edge and is never all-zero in between.
- A reset assertion mid-grant forces all outputs to their reset values asynchronously. After release, the first search starts at requester 0.
- An owner requesting continuously with no competitors never loses its grant.

## Structure
- Package `led_arb_pkg` holds:
  - the state enum (IDLE, OWN);
  - the `onehot(idx)` function;
  - `clog2`-based index-width constants.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: `req`, `ptr`, `excl_en`, `excl_idx`.
  - Outputs: `found`, `idx`.
  - Instantiated once by the arbiter FSM.

## Test plan
Benches use N_REQ=4, LED_W=8, HOLD_CYCLES=4.
- Reset, then `req`=0001 with `req_led[0]`=8'hA5: at t+1, `grant`=0001, `led_out`=A5, `busy`=1; with the request held and no competitors the grant stays indefinitely.
- `req`=1111 held constant: the grant sequence is 0001, 0010, 0100, 1000, 0001, and each grant lasts exactly 4 cycles.
- Owner 1 drops `req` 2 cycles into its grant with `led_out`=3C: `led_out` stays 3C until `hold_cnt`=3. The arbiter then goes to IDLE (`led_out`=00) if no one is pending, or to the next pending requester.
- Owner 2 in its 1st hold cycle, then `prio_lock`=1 and `req[0]`=1: `grant`=0001 next cycle. When `req[0]` drops after 4 cycles, the rotation continues from index 3.
- Assert `reset_reset_n`=0 mid-grant: `grant`, `led_out` and `busy` go to 0 without waiting for a clock edge. After release with `req`=1010, the first grant is 0010.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter: FSM state encoding,
// index-width constants and the one-hot encoder used to build grant vectors.
package led_arb_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = $clog2(MAX_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = {MAX_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/led_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr (with wrap),
// optionally skipping one index so a current owner can be excluded.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    logic [IDX_W-1:0] idx_s;

    // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the owner itself comes last, so it is never preferred.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found_s && req[cand_s] && !(excl_en && (cand_s == excl_idx))) begin
                found_s = 1'b1;
                idx_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign found = found_s;
    assign idx   = idx_s;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin LED bank arbiter with minimum hold time and a requester-0
// priority override; all outputs are registered.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int LED_W       = 8,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LED_W-1:0] req_led,
    input  logic                   prio_lock,
    output logic [N_REQ-1:0]       grant,
    output logic [LED_W-1:0]       led_out,
    output logic                   busy
);

    localparam int               IDX_W     = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GRANT_0   = N_REQ'(1);

    state_e           state_r,    state_nxt_s;
    logic [IDX_W-1:0] owner_r,    owner_nxt_s;
    logic [IDX_W-1:0] ptr_r,      ptr_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_nxt_s;
    logic [N_REQ-1:0] grant_r,    grant_nxt_s;
    logic [LED_W-1:0] led_r,      led_nxt_s;
    logic             busy_r;

    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               excl_en_s;
    logic [MAX_REQ-1:0] pick_oh_s;
    logic [N_REQ-1:0]   grant_pick_s;
    logic [LED_W-1:0]   pick_led_s;
    logic [LED_W-1:0]   owner_led_s;
    logic               owner_req_s;
    logic               expired_s;
    logic               preempt_s;

    assign excl_en_s = (state_r == ST_OWN);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .ptr      (ptr_r),
        .excl_en  (excl_en_s),
        .excl_idx (owner_r),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Decode helpers: winner grant/pattern, owner pattern, expiry and preemption.
    always_comb begin
        pick_oh_s    = onehot(MAX_IDX_W'(pick_idx_s));
        grant_pick_s = pick_oh_s[N_REQ-1:0];
        pick_led_s   = req_led[int'(pick_idx_s)*LED_W +: LED_W];
        owner_led_s  = req_led[int'(owner_r)*LED_W +: LED_W];
        owner_req_s  = req[owner_r];
        expired_s    = (hold_cnt_r == HOLD_LAST);
        preempt_s    = (state_r == ST_OWN) && prio_lock && req[0] && (owner_r != {IDX_W{1'b0}});
    end

    // Next-state logic; preemption is checked before expiry so it wins a tie.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        ptr_nxt_s   = ptr_r;
        hold_nxt_s  = hold_cnt_r;
        grant_nxt_s = grant_r;
        led_nxt_s   = led_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_OWN;
                    owner_nxt_s = pick_idx_s;
                    ptr_nxt_s   = pick_idx_s;
                    hold_nxt_s  = {CNT_W{1'b0}};
                    grant_nxt_s = grant_pick_s;
                    led_nxt_s   = pick_led_s;
                end else begin
                    grant_nxt_s = {N_REQ{1'b0}};
                    led_nxt_s   = {LED_W{1'b0}};
                end
            end
            ST_OWN: begin
                if (preempt_s) begin
                    // ptr is deliberately left alone so rotation resumes where it was.
                    owner_nxt_s = {IDX_W{1'b0}};
                    hold_nxt_s  = {CNT_W{1'b0}};
                    grant_nxt_s = GRANT_0;
                    led_nxt_s   = req_led[LED_W-1:0];
                end else if (expired_s) begin
                    if (pick_found_s) begin
                        owner_nxt_s = pick_idx_s;
                        ptr_nxt_s   = pick_idx_s;
                        hold_nxt_s  = {CNT_W{1'b0}};
                        grant_nxt_s = grant_pick_s;
                        led_nxt_s   = pick_led_s;
                    end else if (owner_req_s) begin
                        led_nxt_s = owner_led_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        grant_nxt_s = {N_REQ{1'b0}};
                        led_nxt_s   = {LED_W{1'b0}};
                    end
                end else begin
                    hold_nxt_s = hold_cnt_r + CNT_W'(1);
                    if (owner_req_s) begin
                        led_nxt_s = owner_led_s;
                    end else begin
                        led_nxt_s = led_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hold_nxt_s  = {CNT_W{1'b0}};
                grant_nxt_s = {N_REQ{1'b0}};
                led_nxt_s   = {LED_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset leaves ptr on the last index so requester 0 wins first.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= {IDX_W{1'b0}};
            ptr_r      <= PTR_RST;
            hold_cnt_r <= {CNT_W{1'b0}};
            grant_r    <= {N_REQ{1'b0}};
            led_r      <= {LED_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            grant_r    <= grant_nxt_s;
            led_r      <= led_nxt_s;
            busy_r     <= |grant_nxt_s;
        end
    end

    assign grant   = grant_r;
    assign led_out = led_r;
    assign busy    = busy_r;

endmodule
